// File: rtl/coin_acceptor_pkg.sv
// coin_acceptor_pkg: shared types and parameter limits for the coin front-end.
//   coin_e      - queued event encoding (COIN_1 = 1'b0, COIN_2 = 1'b1)
//   out_state_e - output pulse FSM states
//   *_MIN/*_MAX - legal parameter ranges, clamp_param() applies them
package coin_acceptor_pkg;

  typedef enum logic {COIN_1 = 1'b0, COIN_2 = 1'b1} coin_e;

  typedef enum logic [1:0] {IDLE = 2'd0, EMIT = 2'd1, GAP = 2'd2} out_state_e;

  localparam int DEBOUNCE_MIN = 2;
  localparam int DEBOUNCE_MAX = 255;
  localparam int GAP_MIN      = 1;
  localparam int GAP_MAX      = 15;

  function automatic int clamp_param(int v, int lo, int hi);
    return (v < lo) ? lo : ((v > hi) ? hi : v);
  endfunction

endpackage

// File: rtl/coin_debouncer.sv
// coin_debouncer: two-flop synchroniser, stability counter and registered
// rising-edge detector for one raw coin sensor.
//   clk, reset : system clock, async active-high reset
//   sense_i    : raw asynchronous sensor line
//   rise_o     : one-cycle pulse when the debounced level goes 0->1
module coin_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic sense_i,
  output logic rise_o
);

  localparam logic [7:0] CNT_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic       sync1_q, sync2_q;
  logic       level_q, level_d;
  logic       prev_q, rise_q;
  logic [7:0] cnt_q, cnt_d;

  // Count consecutive cycles the synchronised input disagrees with the
  // debounced level; any agreeing sample restarts the count.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) level_d = sync2_q;
      else                   cnt_d   = cnt_q + 8'd1;
    end
  end

  // Levels reset high (synchroniser too) so a sensor held high through
  // reset must first be seen low-stable before it can produce an event.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      prev_q  <= 1'b1;
      cnt_q   <= '0;
      rise_q  <= 1'b0;
    end else begin
      sync1_q <= sense_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      prev_q  <= level_q;
      cnt_q   <= cnt_d;
      rise_q  <= level_q & ~prev_q;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/coin_acceptor.sv
// coin_acceptor: debounces two coin sensors, queues accepted coins in arrival
// order and replays them as single-cycle pulses separated by an idle gap.
//   clk, reset   : system clock, async active-high reset
//   coin_1_sense : raw Rs1 sensor      coin_2_sense : raw Rs2 sensor
//   enable       : 1 = accept coins, 0 = refuse every detected coin
//   coin_1/2     : one-cycle pulse per accepted coin
//   reject       : one-cycle pulse in any cycle that refuses a coin
//   queue_level  : number of queued events
module coin_acceptor
  import coin_acceptor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int GAP_CYCLES      = 2,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          coin_1_sense,
  input  logic                          coin_2_sense,
  input  logic                          enable,
  output logic                          coin_1,
  output logic                          coin_2,
  output logic                          reject,
  output logic [$clog2(FIFO_DEPTH):0]   queue_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DB = clamp_param(DEBOUNCE_CYCLES, DEBOUNCE_MIN, DEBOUNCE_MAX);
  localparam int GP = clamp_param(GAP_CYCLES, GAP_MIN, GAP_MAX);
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [3:0]    GAP_L   = 4'(GP);

  logic rise1, rise2;

  coin_debouncer #(.DEBOUNCE_CYCLES(DB)) u_deb1 (
    .clk(clk), .reset(reset), .sense_i(coin_1_sense), .rise_o(rise1));
  coin_debouncer #(.DEBOUNCE_CYCLES(DB)) u_deb2 (
    .clk(clk), .reset(reset), .sense_i(coin_2_sense), .rise_o(rise2));

  logic [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]         wr_q, wr_d, rd_q, rd_d;
  logic [LW-1:0]         cnt_q, cnt_d, room;
  logic                  pop, reject_q, reject_d;
  out_state_e            state_q, state_d;
  logic [3:0]            gap_q, gap_d;
  coin_e                 cur_q, cur_d;

  always_comb begin
    mem_d    = mem_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    reject_d = 1'b0;
    state_d  = state_q;
    gap_d    = gap_q;
    cur_d    = cur_q;
    pop      = 1'b0;
    // Free space is judged before this cycle's pop; Rs1 claims a slot first.
    room     = DEPTH_L - cnt_q;

    if (rise1) begin
      if (enable && room != '0) begin
        mem_d[wr_d] = COIN_1;
        wr_d        = wr_d + 1'b1;
        room        = room - 1'b1;
      end else begin
        reject_d = 1'b1;
      end
    end
    if (rise2) begin
      if (enable && room != '0) begin
        mem_d[wr_d] = COIN_2;
        wr_d        = wr_d + 1'b1;
        room        = room - 1'b1;
      end else begin
        reject_d = 1'b1;
      end
    end

    unique case (state_q)
      IDLE: if (cnt_q != '0) begin
        pop     = 1'b1;
        cur_d   = coin_e'(mem_q[rd_q]);
        rd_d    = rd_q + 1'b1;
        state_d = EMIT;
      end
      EMIT: begin
        state_d = GAP;
        gap_d   = GAP_L;
      end
      GAP: begin
        if (gap_q == 4'd1) state_d = IDLE;
        else               gap_d   = gap_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase

    // Net change: pushes this cycle minus the pop.
    cnt_d = cnt_q + ((DEPTH_L - cnt_q) - room) - LW'(pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      reject_q <= 1'b0;
      state_q  <= IDLE;
      gap_q    <= '0;
      cur_q    <= COIN_1;
    end else begin
      mem_q    <= mem_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      reject_q <= reject_d;
      state_q  <= state_d;
      gap_q    <= gap_d;
      cur_q    <= cur_d;
    end
  end

  assign coin_1      = (state_q == EMIT) && (cur_q == COIN_1);
  assign coin_2      = (state_q == EMIT) && (cur_q == COIN_2);
  assign reject      = reject_q;
  assign queue_level = cnt_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// tb_coin_acceptor: randomized sensor waveforms checked cycle by cycle against
// an event-level model (coin queue + earliest-next-pulse time).
module tb_coin_acceptor;

  localparam int D     = 4;
  localparam int G     = 8;
  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;
  localparam int N     = 700;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic coin_1_sense = 1'b0, coin_2_sense = 1'b0, enable = 1'b1;
  logic coin_1, coin_2, reject;
  logic [LW-1:0] queue_level;

  coin_acceptor #(.DEBOUNCE_CYCLES(D), .GAP_CYCLES(G), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .coin_1_sense(coin_1_sense), .coin_2_sense(coin_2_sense),
    .enable(enable), .coin_1(coin_1), .coin_2(coin_2), .reject(reject),
    .queue_level(queue_level));

  always #5 clk = ~clk;

  int checks = 0, failures = 0, cyc = 0;
  int q[$];
  int next_ok = 0, last_emit = -100;
  int rejects_seen = 0;
  bit w1[N], w2[N], en_w[N], ev1[N], ev2[N];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  task automatic clear_stim();
    for (int i = 0; i < N; i++) begin
      w1[i] = 0; w2[i] = 0; en_w[i] = 1; ev1[i] = 0; ev2[i] = 0;
    end
  endtask

  task automatic put(input int line, input int t, input bit v);
    if (t < N) begin
      if (line == 1) w1[t] = v; else w2[t] = v;
    end
  endtask

  // A stable high run starting at index s is enqueued at edge s+D+3.
  task automatic mark(input int line, input int s);
    if (s + D + 3 < N) begin
      if (line == 1) ev1[s + D + 3] = 1; else ev2[s + D + 3] = 1;
    end
  endtask

  task automatic gen_line(input int line, input int start, input int stop, input bit rnd);
    int t, lo, hi, g;
    t = start;
    while (t < stop) begin
      lo = rnd ? D + 2 + int'($urandom_range(0, 6)) : D + 2;
      for (int k = 0; k < lo; k++) begin put(line, t, 0); t++; end
      if (rnd && $urandom_range(0, 2) == 0) begin
        g = int'($urandom_range(1, D - 1));
        for (int k = 0; k < g; k++) begin put(line, t, 1); t++; end
        lo = D + 2 + int'($urandom_range(0, 3));
        for (int k = 0; k < lo; k++) begin put(line, t, 0); t++; end
      end
      hi = rnd ? D + int'($urandom_range(0, 4)) : D;
      mark(line, t);
      for (int k = 0; k < hi; k++) begin put(line, t, 1); t++; end
    end
  endtask

  task automatic run(input int ncyc, input bit stop_gap3, output bit stopped);
    int ep, free;
    bit er;
    stopped = 0;
    for (int n = 0; n < ncyc; n++) begin
      coin_1_sense = w1[n]; coin_2_sense = w2[n]; enable = en_w[n];
      @(posedge clk);
      cyc++;
      ep = -1; er = 0; free = DEPTH - q.size();
      if (q.size() != 0 && cyc >= next_ok) begin
        ep = q.pop_front(); next_ok = cyc + G + 2; last_emit = cyc;
      end
      if (ev1[n]) begin
        if (en_w[n] && free > 0) begin q.push_back(0); free--; end else er = 1;
      end
      if (ev2[n]) begin
        if (en_w[n] && free > 0) begin q.push_back(1); free--; end else er = 1;
      end
      if (er) rejects_seen++;
      #1;
      chk("coin_1", coin_1, ep == 0);
      chk("coin_2", coin_2, ep == 1);
      chk("reject", reject, er);
      chk("queue_level", queue_level, q.size());
      if (stop_gap3 && q.size() >= 3 && cyc > last_emit && cyc <= last_emit + G) begin
        stopped = 1;
        break;
      end
    end
  endtask

  initial begin
    bit stopped;
    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_coin_1", coin_1, 0);
    chk("rst_coin_2", coin_2, 0);
    chk("rst_reject", reject, 0);
    chk("rst_level", queue_level, 0);
    reset = 1'b0;

    // Phase A: simultaneous coins first, then random bounce/glitch/enable traffic.
    clear_stim();
    for (int i = 10; i < 18; i++) begin w1[i] = 1; w2[i] = 1; end
    mark(1, 10); mark(2, 10);
    gen_line(1, 18, N - 40, 1);
    gen_line(2, 18, N - 40, 1);
    begin
      int i = 40, len;
      bit v;
      while (i < N) begin
        len = int'($urandom_range(15, 50));
        v = ($urandom_range(0, 3) != 0);
        for (int k = 0; k < len && i < N; k++) begin en_w[i] = v; i++; end
      end
    end
    run(N, 0, stopped);

    // Phase B: steady paired coins fill the queue; stop in GAP with 3 queued.
    clear_stim();
    gen_line(1, 0, 200, 0);
    gen_line(2, 0, 200, 0);
    run(200, 1, stopped);

    // Asynchronous reset mid-operation, sensors held high across release.
    #2;
    reset = 1'b1; coin_1_sense = 1'b1; coin_2_sense = 1'b1;
    #1;
    chk("midrst_coin_1", coin_1, 0);
    chk("midrst_coin_2", coin_2, 0);
    chk("midrst_reject", reject, 0);
    chk("midrst_level", queue_level, 0);
    q.delete();
    next_ok = 0;
    @(posedge clk); @(posedge clk);
    #1 reset = 1'b0;

    // Phase C: sensor still high at release, then falls: no events at all.
    clear_stim();
    for (int i = 0; i < 20; i++) begin w1[i] = 1; w2[i] = 1; end
    run(45, 0, stopped);

    // Phase D: sustained paired coins overflow the queue.
    clear_stim();
    gen_line(1, 0, 150, 0);
    gen_line(2, 0, 150, 0);
    run(200, 0, stopped);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
